// File: rtl/grf_writeback_pkg.sv
// rtl/grf_writeback_pkg.sv - shared widths and write-back source encodings for the W stage
// The WD_* encodings are also used by the controller that drives W_WDSel.
package grf_writeback_pkg;

  localparam int unsigned GRF_DATA_W = 32;
  localparam int unsigned GRF_NREG   = 32;
  localparam int unsigned GRF_ADDR_W = 5;

  typedef enum logic [2:0] {
    WD_ALU = 3'd0,
    WD_DM  = 3'd1,
    WD_PC8 = 3'd2,
    WD_MDU = 3'd3,
    WD_CP0 = 3'd4,
    WD_EXT = 3'd5
  } wd_sel_e;

endpackage

// File: rtl/grf_writeback_wb_data_sel.sv
// rtl/grf_writeback_wb_data_sel.sv - combinational write-back source mux incl. PC+8 link value
// Unused encodings (6/7) and unknown selects yield zero.
module wb_data_sel
  import grf_writeback_pkg::*;
#(
  parameter int unsigned DATA_W = GRF_DATA_W
) (
  input  logic [2:0]        i_sel,
  input  logic [DATA_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_mdu,
  input  logic [DATA_W-1:0] i_dm,
  input  logic [DATA_W-1:0] i_cp0,
  input  logic [DATA_W-1:0] i_ext,
  output logic [DATA_W-1:0] o_wd
);

  logic [DATA_W-1:0] w_pc8;

  assign w_pc8 = i_pc + {{(DATA_W-4){1'b0}}, 4'd8};

  always_comb begin
    o_wd = '0;
    case (i_sel)
      WD_ALU:  o_wd = i_alu;
      WD_DM:   o_wd = i_dm;
      WD_PC8:  o_wd = w_pc8;
      WD_MDU:  o_wd = i_mdu;
      WD_CP0:  o_wd = i_cp0;
      WD_EXT:  o_wd = i_ext;
      default: o_wd = '0;
    endcase
  end

endmodule

// File: rtl/grf_writeback.sv
// rtl/grf_writeback.sv - W-stage write-back: GRF array, bypassed D-stage reads, commit trace, retire count
// Register $0 is never stored; reads of address 0 return zero.
module grf_writeback
  import grf_writeback_pkg::*;
#(
  parameter int unsigned DATA_W = GRF_DATA_W,
  parameter int unsigned NREG   = GRF_NREG,
  parameter int unsigned ADDR_W = GRF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              W_valid,
  input  logic [31:0]       W_PC,
  input  logic              W_RegWrite,
  input  logic [ADDR_W-1:0] W_RegAddr,
  input  logic [2:0]        W_WDSel,
  input  logic [DATA_W-1:0] W_ALU,
  input  logic [DATA_W-1:0] W_MDU,
  input  logic [DATA_W-1:0] W_DM,
  input  logic [DATA_W-1:0] W_CP0,
  input  logic [DATA_W-1:0] W_EXT,
  input  logic [ADDR_W-1:0] D_rs_addr,
  input  logic [ADDR_W-1:0] D_rt_addr,
  output logic [DATA_W-1:0] D_rs_data,
  output logic [DATA_W-1:0] D_rt_data,
  output logic [DATA_W-1:0] W_WD,
  output logic              trace_valid,
  output logic [31:0]       trace_pc,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data,
  output logic [31:0]       retire_cnt
);

  logic [DATA_W-1:0] r_regs [NREG];
  logic              r_trace_valid;
  logic [31:0]       r_trace_pc;
  logic [ADDR_W-1:0] r_trace_addr;
  logic [DATA_W-1:0] r_trace_data;
  logic [31:0]       r_retire_cnt;

  logic [DATA_W-1:0] w_wd;
  logic              w_wr_en;
  logic [31:0]       w_pc_ext;

  assign w_pc_ext = W_PC;

  wb_data_sel #(.DATA_W(DATA_W)) u_wb_data_sel (
    .i_sel (W_WDSel),
    .i_pc  (w_pc_ext[DATA_W-1:0]),
    .i_alu (W_ALU),
    .i_mdu (W_MDU),
    .i_dm  (W_DM),
    .i_cp0 (W_CP0),
    .i_ext (W_EXT),
    .o_wd  (w_wd)
  );

  assign w_wr_en = W_valid & W_RegWrite & (W_RegAddr != '0);
  assign W_WD    = w_wd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[W_RegAddr] <= w_wd;
    end
  end

  // Same-cycle W->D bypass so D never sees a stale value for the register being committed.
  always_comb begin
    D_rs_data = r_regs[D_rs_addr];
    if (D_rs_addr == '0) begin
      D_rs_data = '0;
    end else if (w_wr_en && (D_rs_addr == W_RegAddr)) begin
      D_rs_data = w_wd;
    end
  end

  always_comb begin
    D_rt_data = r_regs[D_rt_addr];
    if (D_rt_addr == '0) begin
      D_rt_data = '0;
    end else if (w_wr_en && (D_rt_addr == W_RegAddr)) begin
      D_rt_data = w_wd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_trace_valid <= 1'b0;
      r_trace_pc    <= '0;
      r_trace_addr  <= '0;
      r_trace_data  <= '0;
    end else begin
      r_trace_valid <= w_wr_en;
      if (w_wr_en) begin
        r_trace_pc   <= W_PC;
        r_trace_addr <= W_RegAddr;
        r_trace_data <= w_wd;
      end
    end
  end

  // Counts retired instructions whether or not they write the GRF.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retire_cnt <= '0;
    end else if (W_valid) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign trace_valid = r_trace_valid;
  assign trace_pc    = r_trace_pc;
  assign trace_addr  = r_trace_addr;
  assign trace_data  = r_trace_data;
  assign retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_grf_writeback.sv
// tb/tb_grf_writeback.sv - scoreboard bench for grf_writeback with directed write-back vectors
module tb_grf_writeback;
  import grf_writeback_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        W_valid, W_RegWrite;
  logic [31:0] W_PC;
  logic [4:0]  W_RegAddr;
  logic [2:0]  W_WDSel;
  logic [31:0] W_ALU, W_MDU, W_DM, W_CP0, W_EXT;
  logic [4:0]  D_rs_addr, D_rt_addr;
  logic [31:0] D_rs_data, D_rt_data, W_WD;
  logic        trace_valid;
  logic [31:0] trace_pc, trace_data, retire_cnt;
  logic [4:0]  trace_addr;

  always #5 clk = ~clk;

  grf_writeback dut (
    .clk(clk), .reset(reset), .W_valid(W_valid), .W_PC(W_PC), .W_RegWrite(W_RegWrite),
    .W_RegAddr(W_RegAddr), .W_WDSel(W_WDSel), .W_ALU(W_ALU), .W_MDU(W_MDU), .W_DM(W_DM),
    .W_CP0(W_CP0), .W_EXT(W_EXT), .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_rs_data(D_rs_data), .D_rt_data(D_rt_data), .W_WD(W_WD), .trace_valid(trace_valid),
    .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
    .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_data, m_ret;
  logic [4:0]  m_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (W_valid && W_RegWrite && (W_RegAddr != 5'd0) && (a == W_RegAddr)) return wd;
    return m_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc = 0; m_data = 0; m_ret = 0; m_addr = 0;
  endtask

  task automatic set_vec(input logic v, input logic rw, input logic [4:0] a, input logic [2:0] sel,
                         input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt);
    W_valid = v; W_RegWrite = rw; W_RegAddr = a; W_WDSel = sel; W_PC = pc;
    D_rs_addr = rs; D_rt_addr = rt;
    W_ALU = 32'hA0A0A0A0; W_DM = 32'hD0D0D0D0; W_MDU = 32'h30303030;
    W_CP0 = 32'hC0C0C0C0; W_EXT = 32'hE0E0E0E0;
  endtask

  // Called at posedge+2 with inputs applied; checks combinational outputs, queues the edge's effect.
  task automatic issue(input logic [31:0] exp_wd);
    logic we;
    exp_t e;
    #1;
    chk("W_WD", W_WD, exp_wd);
    chk("rs_data", D_rs_data, mread(D_rs_addr, exp_wd));
    chk("rt_data", D_rt_data, mread(D_rt_addr, exp_wd));
    we = W_valid && W_RegWrite && (W_RegAddr != 5'd0);
    if (we) begin
      m_regs[W_RegAddr] = exp_wd;
      m_pc = W_PC; m_addr = W_RegAddr; m_data = exp_wd;
    end
    if (W_valid) m_ret = m_ret + 32'd1;
    e.v = we; e.pc = m_pc; e.addr = m_addr; e.data = m_data; e.ret = m_ret;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("trace_valid", 32'(trace_valid), 32'(e.v));
      chk("trace_pc", trace_pc, e.pc);
      chk("trace_addr", 32'(trace_addr), 32'(e.addr));
      chk("trace_data", trace_data, e.data);
      chk("retire_cnt", retire_cnt, e.ret);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    set_vec(1'b0, 1'b0, 5'd0, WD_ALU, 32'd0, 5'd0, 5'd0);
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_trace_valid", 32'(trace_valid), 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    #1;

    set_vec(1'b1, 1'b1, 5'd5, WD_ALU, 32'h100, 5'd5, 5'd0); W_ALU = 32'h1234;
    issue(32'h1234);
    set_vec(1'b1, 1'b1, 5'd8, WD_DM, 32'h104, 5'd8, 5'd8); W_DM = 32'hDEADBEEF;
    issue(32'hDEADBEEF);
    set_vec(1'b1, 1'b0, 5'd8, WD_ALU, 32'h108, 5'd5, 5'd8);
    issue(32'hA0A0A0A0);
    set_vec(1'b1, 1'b1, 5'd0, WD_ALU, 32'h10C, 5'd0, 5'd0); W_ALU = 32'hFFFFFFFF;
    issue(32'hFFFFFFFF);
    set_vec(1'b1, 1'b1, 5'd3, WD_PC8, 32'hFFFFFFFC, 5'd3, 5'd8);
    issue(32'h00000004);
    set_vec(1'b1, 1'b1, 5'd4, 3'd6, 32'h200, 5'd4, 5'd3);
    issue(32'h0);
    set_vec(1'b1, 1'b1, 5'd3, 3'd7, 32'h204, 5'd3, 5'd4);
    issue(32'h0);
    set_vec(1'b1, 1'b1, 5'd10, WD_MDU, 32'h208, 5'd10, 5'd5); W_MDU = 32'h55AA;
    issue(32'h55AA);
    set_vec(1'b1, 1'b1, 5'd11, WD_CP0, 32'h20C, 5'd10, 5'd11); W_CP0 = 32'h12345678;
    issue(32'h12345678);
    set_vec(1'b1, 1'b1, 5'd12, WD_EXT, 32'h210, 5'd11, 5'd12); W_EXT = 32'hABCD0000;
    issue(32'hABCD0000);
    set_vec(1'b0, 1'b0, 5'd0, WD_ALU, 32'h0, 5'd12, 5'd5);
    issue(32'hA0A0A0A0);

    // Reset asserted while a write to r7 is being presented.
    set_vec(1'b1, 1'b1, 5'd7, WD_ALU, 32'h300, 5'd7, 5'd7); W_ALU = 32'h77;
    #1;
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #2;
    set_vec(1'b0, 1'b0, 5'd0, WD_ALU, 32'h0, 5'd7, 5'd5);
    reset = 1'b1;
    #1;
    chk("post_rst_rs", D_rs_data, 32'd0);
    chk("post_rst_rt", D_rt_data, 32'd0);
    chk("post_rst_trace_valid", 32'(trace_valid), 32'd0);
    chk("post_rst_trace_data", trace_data, 32'd0);
    chk("post_rst_trace_pc", trace_pc, 32'd0);
    chk("post_rst_retire", retire_cnt, 32'd0);
    @(posedge clk);
    #2;

    for (int i = 0; i < 3; i++) begin
      set_vec(1'b0, 1'b1, 5'd9, WD_ALU, 32'h400 + 32'(i * 4), 5'd9, 5'd9); W_ALU = 32'h9999;
      issue(32'h9999);
    end
    for (int i = 0; i < 2; i++) begin
      set_vec(1'b1, 1'b0, 5'd9, WD_ALU, 32'h500 + 32'(i * 4), 5'd9, 5'd0);
      issue(32'hA0A0A0A0);
    end
    #1;
    chk("bubble_r9", D_rs_data, 32'd0);
    chk("bubble_retire", retire_cnt, 32'd2);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
